// File: rtl/execute_up.sv
// Execute stage of a five-stage Y86-64 pipeline.
// Combinational ALU, condition evaluation and forwarding outputs, plus the
// condition-code register and the E->M pipeline register.
module execute_up (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [63:0] E_valC,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic [1:0]  m_stat,
    input  logic [1:0]  W_stat,
    input  logic        M_bubble,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic        e_Cnd,
    output logic [2:0]  cc,
    output logic [1:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM
);

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // ALU functions (OPq ifun)
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;

    // Condition functions (rrmovq/cmovXX and jXX ifun)
    localparam logic [3:0] C_YES    = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [1:0]  STAT_AOK = 2'd0;
    localparam logic [3:0]  REG_NONE = 4'hF;
    localparam logic [63:0] EIGHT    = 64'd8;
    localparam logic [63:0] NEG8     = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [2:0]  CC_RESET = 3'b100;

    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_fn;
    logic [63:0] sum_val;
    logic [63:0] diff_val;
    logic [63:0] and_val;
    logic [63:0] xor_val;
    logic [63:0] alu_res;
    logic        of_next;
    logic        zf_next;
    logic        sf_next;
    logic        cc_update;
    logic [2:0]  cc_reg;
    logic        zf;
    logic        sf;
    logic        of;
    logic        cnd;

    logic [1:0]  m_stat_reg;
    logic [3:0]  m_icode_reg;
    logic        m_cnd_reg;
    logic [63:0] m_vale_reg;
    logic [63:0] m_vala_reg;
    logic [3:0]  m_dste_reg;
    logic [3:0]  m_dstm_reg;

    // Select ALU operand A by instruction class
    always_comb begin
        alu_a = 64'd0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:                 alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:    alu_a = E_valC;
            I_CALL, I_PUSHQ:                 alu_a = NEG8;
            I_RET, I_POPQ:                   alu_a = EIGHT;
            default:                         alu_a = 64'd0;
        endcase
    end

    // Select ALU operand B; only memory and stack ops plus OPq use valB
    always_comb begin
        alu_b = 64'd0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ:  alu_b = E_valB;
            default:                         alu_b = 64'd0;
        endcase
    end

    // Only OPq takes its ALU function from ifun; address arithmetic adds
    always_comb begin
        alu_fn = ALU_ADD;
        if (E_icode == I_OPQ) begin
            alu_fn = E_ifun;
        end
    end

    assign sum_val  = alu_b + alu_a;
    assign diff_val = alu_b - alu_a;

    // Bitwise logic unit built bit by bit
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_bitwise
            assign and_val[gi] = alu_a[gi] & alu_b[gi];
            assign xor_val[gi] = alu_a[gi] ^ alu_b[gi];
        end
    endgenerate

    // ALU result and overflow; undefined OPq functions yield zero
    always_comb begin
        alu_res = 64'd0;
        of_next = 1'b0;
        case (alu_fn)
            ALU_ADD: begin
                alu_res = sum_val;
                of_next = (alu_a[63] == alu_b[63]) && (sum_val[63] != alu_a[63]);
            end
            ALU_SUB: begin
                alu_res = diff_val;
                of_next = (alu_a[63] != alu_b[63]) && (diff_val[63] != alu_b[63]);
            end
            ALU_AND: alu_res = and_val;
            ALU_XOR: alu_res = xor_val;
            default: begin
                alu_res = 64'd0;
                of_next = 1'b0;
            end
        endcase
    end

    assign zf_next = (alu_res == 64'd0);
    assign sf_next = alu_res[63];
    assign e_valE  = alu_res;

    // Flags are frozen once an exception is already downstream
    assign cc_update = (E_icode == I_OPQ) && (E_ifun <= ALU_XOR) &&
                       (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

    // Condition-code register {ZF,SF,OF}
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_reg <= CC_RESET;
        end else if (cc_update) begin
            cc_reg <= {zf_next, sf_next, of_next};
        end
    end

    assign cc = cc_reg;
    assign zf = cc_reg[2];
    assign sf = cc_reg[1];
    assign of = cc_reg[0];

    // Evaluate branch / conditional-move condition from the stored flags
    always_comb begin
        cnd = 1'b0;
        if ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) begin
            case (E_ifun)
                C_YES:   cnd = 1'b1;
                C_LE:    cnd = (sf ^ of) | zf;
                C_L:     cnd = sf ^ of;
                C_E:     cnd = zf;
                C_NE:    cnd = ~zf;
                C_GE:    cnd = ~(sf ^ of);
                C_G:     cnd = ~(sf ^ of) & ~zf;
                default: cnd = 1'b0;
            endcase
        end
    end

    assign e_Cnd = cnd;

    // A conditional move that fails writes nowhere
    always_comb begin
        e_dstE = E_dstE;
        if ((E_icode == I_RRMOVQ) && !cnd) begin
            e_dstE = REG_NONE;
        end
    end

    // E->M pipeline register: reset and bubble both insert a nop
    always_ff @(posedge clk) begin
        if (!rst_n || M_bubble) begin
            m_stat_reg  <= STAT_AOK;
            m_icode_reg <= I_NOP;
            m_cnd_reg   <= 1'b0;
            m_vale_reg  <= 64'd0;
            m_vala_reg  <= 64'd0;
            m_dste_reg  <= REG_NONE;
            m_dstm_reg  <= REG_NONE;
        end else begin
            m_stat_reg  <= E_stat;
            m_icode_reg <= E_icode;
            m_cnd_reg   <= cnd;
            m_vale_reg  <= alu_res;
            m_vala_reg  <= E_valA;
            m_dste_reg  <= e_dstE;
            m_dstm_reg  <= E_dstM;
        end
    end

    assign M_stat  = m_stat_reg;
    assign M_icode = m_icode_reg;
    assign M_Cnd   = m_cnd_reg;
    assign M_valE  = m_vale_reg;
    assign M_valA  = m_vala_reg;
    assign M_dstE  = m_dste_reg;
    assign M_dstM  = m_dstm_reg;

    // I_HALT is listed for completeness of the opcode map; it needs no ALU work
    logic unused_halt;
    assign unused_halt = (E_icode == I_HALT);

endmodule

// File: tb/tb_execute_up.sv
// Self-checking bench for execute_up: directed vector table followed by
// randomized stimulus against a behavioural model of the execute stage.
module tb_execute_up;

    logic        clk;
    logic        rst_n;
    logic [1:0]  E_stat;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [63:0] E_valC;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [1:0]  m_stat;
    logic [1:0]  W_stat;
    logic        M_bubble;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_Cnd;
    logic [2:0]  cc;
    logic [1:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;

    int checks = 0;
    int errors = 0;

    execute_up dut (
        .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode),
        .E_ifun(E_ifun), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .m_stat(m_stat), .W_stat(W_stat),
        .M_bubble(M_bubble), .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
        .cc(cc), .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] model_valE(input logic [3:0] ic, input logic [3:0] fn,
                                               input logic [63:0] a, input logic [63:0] b,
                                               input logic [63:0] c);
        case (ic)
            4'h2: return a;
            4'h3: return c;
            4'h4, 4'h5: return b + c;
            4'h6: case (fn)
                      4'h0: return b + a;
                      4'h1: return b - a;
                      4'h2: return a & b;
                      4'h3: return a ^ b;
                      default: return 64'd0;
                  endcase
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            default: return 64'd0;
        endcase
    endfunction

    // Overflow judged by whether the exact signed result fits in 64 bits
    function automatic logic [2:0] model_flags(input logic [3:0] fn, input logic [63:0] a,
                                               input logic [63:0] b, input logic [63:0] r);
        logic signed [64:0] wide;
        logic               ovf;
        ovf = 1'b0;
        if (fn == 4'h0) begin
            wide = $signed({a[63], a}) + $signed({b[63], b});
            ovf  = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
        end else if (fn == 4'h1) begin
            wide = $signed({b[63], b}) - $signed({a[63], a});
            ovf  = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
        end
        return {r == 64'd0, r[63], ovf};
    endfunction

    function automatic logic model_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic [2:0] flags);
        logic z, less;
        z    = flags[2];
        less = flags[1] != flags[0];
        if (ic != 4'h2 && ic != 4'h7) return 1'b0;
        case (fn)
            4'h0: return 1'b1;
            4'h1: return less || z;
            4'h2: return less;
            4'h3: return z;
            4'h4: return !z;
            4'h5: return !less;
            4'h6: return !less && !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'(unsigned'($urandom_range(0, 16)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [3:0]  dste;
        logic [1:0]  wstat;
        logic        bub;
        logic [63:0] x_valE;
        logic        x_cnd;
        logic [3:0]  x_dstE;
        logic [2:0]  x_cc;
        logic [3:0]  x_micode;
    } vec_t;

    vec_t vecs [10];

    task automatic set_inputs(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] c, input logic [3:0] de,
                              input logic [3:0] dm, input logic [1:0] es, input logic [1:0] ms,
                              input logic [1:0] ws, input logic bub);
        E_icode = ic; E_ifun = fn; E_valA = a; E_valB = b; E_valC = c;
        E_dstE = de; E_dstM = dm; E_stat = es; m_stat = ms; W_stat = ws; M_bubble = bub;
    endtask

    logic [2:0]  cc_m;
    logic [1:0]  ms_m;
    logic [3:0]  mic_m, mde_m, mdm_m;
    logic        mcnd_m;
    logic [63:0] mve_m, mva_m;

    initial begin
        vecs[0] = '{4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2, 2'd0, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 4'h2, 3'b011, 4'h6};
        vecs[1] = '{4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'h4, 2'd1, 1'b0,
                    64'd0, 1'b0, 4'h4, 3'b011, 4'h6};
        vecs[2] = '{4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h5, 2'd0, 1'b0,
                    64'd0, 1'b0, 4'h5, 3'b100, 4'h6};
        vecs[3] = '{4'h2, 4'h4, 64'd9, 64'd0, 64'd0, 4'h3, 2'd0, 1'b0,
                    64'd9, 1'b0, 4'hF, 3'b100, 4'h2};
        vecs[4] = '{4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 2'd0, 1'b1,
                    64'hF8, 1'b0, 4'h4, 3'b100, 4'h1};
        vecs[5] = '{4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h6, 2'd0, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'h6, 3'b010, 4'h6};
        vecs[6] = '{4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF, 2'd0, 1'b0,
                    64'd0, 1'b1, 4'hF, 3'b010, 4'h7};
        vecs[7] = '{4'h7, 4'h5, 64'd0, 64'd0, 64'h40, 4'hF, 2'd0, 1'b0,
                    64'd0, 1'b0, 4'hF, 3'b010, 4'h7};
        vecs[8] = '{4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 4'h1, 2'd0, 1'b1,
                    64'd0, 1'b0, 4'h1, 3'b100, 4'h1};
        vecs[9] = '{4'h2, 4'h0, 64'h1234, 64'd0, 64'd0, 4'h7, 2'd0, 1'b0,
                    64'h1234, 1'b1, 4'h7, 3'b100, 4'h2};

        // Reset for one edge with a live instruction on the inputs
        rst_n = 1'b0;
        set_inputs(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 4'h2, 4'h3, 2'd0, 2'd0, 2'd0, 1'b0);
        #2;
        chk("reset_comb_valE", e_valE, 64'd7);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("reset_M_icode", 64'(M_icode), 64'h1);
        chk("reset_M_dstE", 64'(M_dstE), 64'hF);
        chk("reset_M_dstM", 64'(M_dstM), 64'hF);
        chk("reset_M_valE", M_valE, 64'd0);
        chk("reset_M_stat", 64'(M_stat), 64'd0);
        chk("reset_cc", 64'(cc), 64'(3'b100));
        $display("txn reset: M_icode=%h cc=%b", M_icode, cc);

        for (int i = 0; i < 10; i++) begin
            set_inputs(vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].c,
                       vecs[i].dste, 4'h8, 2'd0, 2'd0, vecs[i].wstat, vecs[i].bub);
            #2;
            chk($sformatf("vec%0d_e_valE", i), e_valE, vecs[i].x_valE);
            chk($sformatf("vec%0d_e_Cnd", i), 64'(e_Cnd), 64'(vecs[i].x_cnd));
            chk($sformatf("vec%0d_e_dstE", i), 64'(e_dstE), 64'(vecs[i].x_dstE));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_cc", i), 64'(cc), 64'(vecs[i].x_cc));
            chk($sformatf("vec%0d_M_icode", i), 64'(M_icode), 64'(vecs[i].x_micode));
            chk($sformatf("vec%0d_M_valE", i), M_valE, vecs[i].bub ? 64'd0 : vecs[i].x_valE);
            chk($sformatf("vec%0d_M_valA", i), M_valA, vecs[i].bub ? 64'd0 : vecs[i].a);
            chk($sformatf("vec%0d_M_dstE", i), 64'(M_dstE), vecs[i].bub ? 64'hF : 64'(vecs[i].x_dstE));
            chk($sformatf("vec%0d_M_dstM", i), 64'(M_dstM), vecs[i].bub ? 64'hF : 64'h8);
            chk($sformatf("vec%0d_M_Cnd", i), 64'(M_Cnd), vecs[i].bub ? 64'd0 : 64'(vecs[i].x_cnd));
            $display("txn vec%0d: icode=%h ifun=%h valE=%h cnd=%b cc=%b M_icode=%h",
                     i, vecs[i].icode, vecs[i].ifun, e_valE, e_Cnd, cc, M_icode);
        end

        // Randomized phase; start from a known reset state
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cc_m = 3'b100; ms_m = 2'd0; mic_m = 4'h1; mcnd_m = 1'b0;
        mve_m = 64'd0; mva_m = 64'd0; mde_m = 4'hF; mdm_m = 4'hF;

        for (int t = 0; t < 400; t++) begin
            logic [63:0] xv;
            logic        xc;
            logic [3:0]  xd;
            logic [3:0]  fn;
            logic [1:0]  ms, ws;
            fn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            ms = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            ws = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            set_inputs(4'($urandom_range(0, 15)), fn, rand64(), rand64(), rand64(),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       2'($urandom_range(0, 3)), ms, ws, ($urandom_range(0, 7) == 0));
            rst_n = ($urandom_range(0, 24) != 0);
            xv = model_valE(E_icode, E_ifun, E_valA, E_valB, E_valC);
            xc = model_cnd(E_icode, E_ifun, cc_m);
            xd = (E_icode == 4'h2 && !xc) ? 4'hF : E_dstE;
            #2;
            chk("rnd_e_valE", e_valE, xv);
            chk("rnd_e_Cnd", 64'(e_Cnd), 64'(xc));
            chk("rnd_e_dstE", 64'(e_dstE), 64'(xd));
            // Model the edge
            if (!rst_n) begin
                cc_m = 3'b100;
            end else if (E_icode == 4'h6 && E_ifun <= 4'h3 && ms == 2'd0 && ws == 2'd0) begin
                cc_m = model_flags(E_ifun, E_valA, E_valB, xv);
            end
            if (!rst_n || M_bubble) begin
                ms_m = 2'd0; mic_m = 4'h1; mcnd_m = 1'b0; mve_m = 64'd0;
                mva_m = 64'd0; mde_m = 4'hF; mdm_m = 4'hF;
            end else begin
                ms_m = E_stat; mic_m = E_icode; mcnd_m = xc; mve_m = xv;
                mva_m = E_valA; mde_m = xd; mdm_m = E_dstM;
            end
            @(posedge clk); #1;
            chk("rnd_cc", 64'(cc), 64'(cc_m));
            chk("rnd_M_stat", 64'(M_stat), 64'(ms_m));
            chk("rnd_M_icode", 64'(M_icode), 64'(mic_m));
            chk("rnd_M_Cnd", 64'(M_Cnd), 64'(mcnd_m));
            chk("rnd_M_valE", M_valE, mve_m);
            chk("rnd_M_valA", M_valA, mva_m);
            chk("rnd_M_dstE", 64'(M_dstE), 64'(mde_m));
            chk("rnd_M_dstM", 64'(M_dstM), 64'(mdm_m));
            $display("txn rnd%0d: rst_n=%b bub=%b icode=%h ifun=%h valE=%h cc=%b",
                     t, rst_n, M_bubble, E_icode, E_ifun, e_valE, cc);
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
